switch_debouncer: RTL and testbench

- Input-conditioning stage directly upstream of the CPU's memory-mapped switch input, between the board slide switches and the `switches` port.
- Synchronises each asynchronous raw switch into `clk` and debounces it with its own stability counter and two-state FSM.
- Presents clean levels, plus one-cycle rise/fall pulses, so DMIO switch reads never see metastable or bouncing values.

---
 rtl/switch_debouncer.sv | 130 +++++++++++++
 tb/tb_switch_debouncer.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/switch_debouncer.sv
// rtl/switch_debouncer.sv - per-channel switch synchroniser and debouncer
//
// Purpose:
//   Takes raw board slide-switch levels, synchronises each one into clk
//   and debounces it with its own stability counter and two-state FSM.
//   The outputs are clean levels plus one-cycle rise/fall pulses.
//
// Ports:
//   clk           system clock, all state updates on its rising edge
//   rst_n         asynchronous active-low reset
//   raw_switches  raw switch levels, asynchronous to clk
//   switches      debounced levels
//   rise          one-cycle pulse per channel on a debounced 0->1
//   fall          one-cycle pulse per channel on a debounced 1->0
//   any_change    OR of all rise and fall bits

module switch_debouncer #(
    parameter int WIDTH         = 8,
    parameter int STABLE_CYCLES = 50000,
    parameter int CNT_BITS      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw_switches,
    output logic [WIDTH-1:0] switches,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             any_change
);

    // Parameter sanity: the counter must be able to hold STABLE_CYCLES-1.
    generate
        if (WIDTH < 1) begin : gen_bad_width
            $error("switch_debouncer: WIDTH must be >= 1");
        end
        if (STABLE_CYCLES < 1) begin : gen_bad_stable
            $error("switch_debouncer: STABLE_CYCLES must be >= 1");
        end
        if ((longint'(STABLE_CYCLES) - 64'sd1) >= (longint'(1) << CNT_BITS)) begin : gen_bad_cnt
            $error("switch_debouncer: CNT_BITS too small for STABLE_CYCLES");
        end
    endgenerate

    localparam logic [CNT_BITS-1:0] LP_LAST = CNT_BITS'(STABLE_CYCLES - 1);

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_CHECK  = 1'b1
    } state_t;

    // Two-flop synchroniser; only the second stage feeds the FSMs.
    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= raw_switches;
            r_sync2 <= r_sync1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : gen_ch
            state_t              r_state;
            logic [CNT_BITS-1:0] r_cnt;
            logic                r_level;
            logic                r_rise;
            logic                r_fall;
            logic                w_mismatch;

            assign w_mismatch = r_sync2[gi] ^ r_level;

            // A channel commits only after the synchronised input has
            // disagreed with the debounced level for STABLE_CYCLES
            // consecutive CHECK evaluations; any agreement in between
            // throws the count away.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_state <= ST_STABLE;
                    r_cnt   <= '0;
                    r_level <= 1'b0;
                    r_rise  <= 1'b0;
                    r_fall  <= 1'b0;
                end else begin
                    // Pulses last exactly one cycle after the commit edge.
                    r_rise <= 1'b0;
                    r_fall <= 1'b0;
                    case (r_state)
                        ST_STABLE: begin
                            r_cnt <= '0;
                            if (w_mismatch) begin
                                r_state <= ST_CHECK;
                            end
                        end
                        ST_CHECK: begin
                            if (!w_mismatch) begin
                                // Input bounced back to the current level.
                                r_state <= ST_STABLE;
                                r_cnt   <= '0;
                            end else if (r_cnt == LP_LAST) begin
                                r_level <= r_sync2[gi];
                                r_rise  <= r_sync2[gi];
                                r_fall  <= ~r_sync2[gi];
                                r_state <= ST_STABLE;
                                r_cnt   <= '0;
                            end else begin
                                r_cnt <= r_cnt + CNT_BITS'(1);
                            end
                        end
                        default: begin
                            r_state <= ST_STABLE;
                            r_cnt   <= '0;
                        end
                    endcase
                end
            end

            assign switches[gi] = r_level;
            assign rise[gi]     = r_rise;
            assign fall[gi]     = r_fall;
        end
    endgenerate

    assign any_change = |{rise, fall};

endmodule

// File: tb/tb_switch_debouncer.sv
// tb/tb_switch_debouncer.sv - scoreboard bench for switch_debouncer

module tb_switch_debouncer;

    logic       clk;
    logic       rst_n;
    logic [7:0] raw_a, sw_a, rise_a, fall_a;
    logic       any_a;
    logic [7:0] raw_b, sw_b, rise_b, fall_b;
    logic       any_b;

    int cyc;
    int vectors;
    int miscompares;

    typedef struct {
        int         cyc;
        logic [7:0] sw;
        logic [7:0] r;
        logic [7:0] f;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];

    switch_debouncer #(.WIDTH(8), .STABLE_CYCLES(4), .CNT_BITS(16)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .raw_switches(raw_a),
        .switches(sw_a), .rise(rise_a), .fall(fall_a), .any_change(any_a)
    );

    switch_debouncer #(.WIDTH(8), .STABLE_CYCLES(1), .CNT_BITS(16)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .raw_switches(raw_b),
        .switches(sw_b), .rise(rise_b), .fall(fall_b), .any_change(any_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%02h expected 0x%02h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitors: every pulse the DUT presents must match the next expected event.
    always @(negedge clk) begin
        if (any_a) begin
            exp_t e;
            vectors++;
            if (q_a.size() == 0) begin
                miscompares++;
                $display("FAIL pulse_a: unexpected pulse cyc=%0d sw=0x%02h rise=0x%02h fall=0x%02h",
                         cyc, sw_a, rise_a, fall_a);
            end else begin
                e = q_a.pop_front();
                if (e.cyc != cyc || e.sw !== sw_a || e.r !== rise_a || e.f !== fall_a) begin
                    miscompares++;
                    $display("FAIL pulse_a: got cyc=%0d sw=0x%02h rise=0x%02h fall=0x%02h expected cyc=%0d sw=0x%02h rise=0x%02h fall=0x%02h",
                             cyc, sw_a, rise_a, fall_a, e.cyc, e.sw, e.r, e.f);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (any_b) begin
            exp_t e;
            vectors++;
            if (q_b.size() == 0) begin
                miscompares++;
                $display("FAIL pulse_b: unexpected pulse cyc=%0d sw=0x%02h rise=0x%02h fall=0x%02h",
                         cyc, sw_b, rise_b, fall_b);
            end else begin
                e = q_b.pop_front();
                if (e.cyc != cyc || e.sw !== sw_b || e.r !== rise_b || e.f !== fall_b) begin
                    miscompares++;
                    $display("FAIL pulse_b: got cyc=%0d sw=0x%02h rise=0x%02h fall=0x%02h expected cyc=%0d sw=0x%02h rise=0x%02h fall=0x%02h",
                             cyc, sw_b, rise_b, fall_b, e.cyc, e.sw, e.r, e.f);
                end
            end
        end
    end

    // Drive a new raw level on DUT A before the next edge k; commit is on k+6.
    task automatic apply_a(input logic [7:0] v, input logic [7:0] er, input logic [7:0] ef);
        @(negedge clk);
        raw_a = v;
        q_a.push_back('{cyc + 1 + 6, v, er, ef});
        repeat (10) @(negedge clk);
    endtask

    // DUT B has STABLE_CYCLES=1: commit on k+3.
    task automatic apply_b(input logic [7:0] v, input logic [7:0] er, input logic [7:0] ef);
        @(negedge clk);
        raw_b = v;
        q_b.push_back('{cyc + 1 + 3, v, er, ef});
        repeat (8) @(negedge clk);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        raw_a = 8'h00;
        raw_b = 8'h00;
        rst_n = 1'b0;
        #1;
        check("reset_switches", sw_a, 8'h00);
        check("reset_rise", rise_a, 8'h00);
        check("reset_fall", fall_a, 8'h00);
        check("reset_any", {7'd0, any_a}, 8'h00);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Clean step on bit 0.
        apply_a(8'h01, 8'h01, 8'h00);

        // Bounce on bit 3: 1,0,1,0 then hold 1.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bounce_hold", sw_a, 8'h01);
            raw_a = (i % 2 == 0) ? 8'h09 : 8'h01;
        end
        @(negedge clk);
        check("bounce_hold", sw_a, 8'h01);
        raw_a = 8'h09;
        q_a.push_back('{cyc + 1 + 6, 8'h09, 8'h08, 8'h00});
        repeat (10) @(negedge clk);

        // All on, then release bit 7.
        apply_a(8'hFF, 8'hF6, 8'h00);
        apply_a(8'h7F, 8'h00, 8'h80);

        // All off, then several channels at once.
        apply_a(8'h00, 8'h00, 8'h7F);
        apply_a(8'hA5, 8'hA5, 8'h00);
        check("simul_level", sw_a, 8'hA5);

        // Reset while channels 7,5,2 are counting.
        @(negedge clk);
        raw_a = 8'h01;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreset_switches", sw_a, 8'h00);
        check("midreset_rise", rise_a, 8'h00);
        check("midreset_fall", fall_a, 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        q_a.push_back('{cyc + 1 + 6, 8'h01, 8'h01, 8'h00});
        repeat (10) @(negedge clk);

        // Long hold: no retrigger over 1000 cycles.
        apply_a(8'h3C, 8'h3C, 8'h01);
        repeat (1000) @(negedge clk);
        check("long_hold", sw_a, 8'h3C);

        // STABLE_CYCLES=1 instance.
        apply_b(8'h01, 8'h01, 8'h00);
        apply_b(8'h00, 8'h00, 8'h01);
        // One-cycle pulse on bit 1 reaches sync2 but only restarts debouncing.
        @(negedge clk);
        raw_b = 8'h02;
        @(negedge clk);
        raw_b = 8'h00;
        repeat (8) @(negedge clk);
        check("glitch_b", sw_b, 8'h00);
        apply_b(8'h40, 8'h40, 8'h00);

        repeat (4) @(negedge clk);
        check("pending_a", 8'(q_a.size()), 8'h00);
        check("pending_b", 8'(q_b.size()), 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
